// File: rtl/enc_dec_pkg.sv
// Shared definitions for the encoder/decoder family.
//   ST_IDLE / ST_EMIT : state encodings used by the serial priority encoder
//   N_DEFAULT         : default request vector width
//   state_t           : FSM state type built on the encodings above
package enc_dec_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EMIT = 1'b1;

  localparam int N_DEFAULT = 8;

  typedef enum logic {
    IDLE = ST_IDLE,
    EMIT = ST_EMIT
  } state_t;

endpackage

// File: rtl/serial_priority_encoder_8to3_prio_enc.sv
// Combinational priority encoder.
//   vec    : input request vector, bit N-1 has highest priority
//   idx    : index of the highest set bit (0 when vec is all zero)
//   any    : at least one bit of vec is set
//   single : exactly one bit of vec is set
module prio_enc_8to3
  import enc_dec_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] idx,
  output logic          any,
  output logic          single
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = CW'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  always_comb begin
    any    = |vec;
    single = any && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/serial_priority_encoder_8to3.sv
// Serial priority encoder: captures an N-bit request vector and emits the
// index of every set bit, highest first, one per output handshake.
//   clk, rst  : clock (rising edge), synchronous active-high reset
//   en        : enable, gates acceptance of a new vector only
//   in_vec    : request vector, in_valid / in_ready handshake
//   code      : index of highest pending bit, out_valid / out_ready handshake
//   out_last  : code is the final pending bit of the vector
//   zero_err  : one-cycle pulse after an all-zero vector was accepted
//   busy      : pending mask non-zero
module serial_priority_encoder_8to3
  import enc_dec_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  in_vec,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          zero_err,
  output logic          busy
);

  state_t         state;
  logic [N-1:0]   pending;
  logic [N-1:0]   next_pending;
  logic [CW-1:0]  next_idx;
  logic           next_any;
  logic           next_single;
  logic           accept;

  // in_ready is forced low while reset is asserted so nothing is taken
  // on a reset edge.
  assign in_ready  = ~rst & en & (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);

  // Pending mask for the next cycle: load on accept, clear the emitted
  // bit on each output handshake.
  always_comb begin
    next_pending = pending;
    case (state)
      IDLE: begin
        if (accept) begin
          next_pending = in_vec;
        end
      end
      EMIT: begin
        if (out_ready) begin
          next_pending = pending & ~(N'(1) << code);
        end
      end
      default: next_pending = pending;
    endcase
  end

  // Encoding the next mask lets code and out_last be registered and
  // valid in the same cycle the pending bits they describe become current.
  prio_enc_8to3 #(.N(N), .CW(CW)) u_prio_enc (
    .vec    (next_pending),
    .idx    (next_idx),
    .any    (next_any),
    .single (next_single)
  );

  // State, pending mask and registered outputs. An all-zero vector never
  // reaches EMIT because next_any stays low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      code     <= '0;
      out_last <= 1'b0;
      zero_err <= 1'b0;
    end else begin
      pending  <= next_pending;
      state    <= next_any ? EMIT : IDLE;
      code     <= next_any ? next_idx : '0;
      out_last <= next_any & next_single;
      zero_err <= accept & ~(|in_vec);
    end
  end

endmodule
